// File: rtl/matrix_loader.sv
// matrix_loader: streams operand A and NUM_ROWS data rows from a synchronous-read
// buffer RAM into the matrix-multiply controller. Row issue is limited by two row credits.
module matrix_loader #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 10,
  parameter int A_WORDS  = 28,
  parameter int ROW_LEN  = 28,
  parameter int NUM_ROWS = 28
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic              load_A_en,
  input  logic              pready,
  input  logic              row_finish,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              start_out,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              data_is_A,
  output logic              load_A_done,
  output logic              load_done,
  output logic              busy,
  output logic              done
);

  localparam int CNT_MAX = (A_WORDS > ROW_LEN) ? A_WORDS : ROW_LEN;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int ROW_W   = $clog2(NUM_ROWS + 1);

  localparam logic [CNT_W-1:0]  A_LAST    = CNT_W'(A_WORDS - 1);
  localparam logic [CNT_W-1:0]  COL_LAST  = CNT_W'(ROW_LEN - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(NUM_ROWS - 1);
  localparam logic [ADDR_W-1:0] ROW0_BASE = ADDR_W'(A_WORDS);
  localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(ROW_LEN);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_A,
    LOAD_A,
    LOAD_ROW,
    HOLD,
    DRAIN
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [CNT_W-1:0]  word_cnt;
  logic [ROW_W-1:0]  row_cnt;
  logic [ADDR_W-1:0] row_base;
  logic [1:0]        credits;
  logic [1:0]        credits_next;
  logic              issue_a;
  logic              issue_row;
  logic              a_last;
  logic              row_end;
  logic              credit_ret;

  // A read goes out whenever the sink is ready in one of the two streaming states.
  assign issue_a   = (state == LOAD_A) && pready;
  assign issue_row = (state == LOAD_ROW) && pready;
  assign a_last    = issue_a && (word_cnt == A_LAST);
  assign row_end   = issue_row && (word_cnt == COL_LAST);
  assign credit_ret = row_finish &&
                      ((state == LOAD_ROW) || (state == HOLD) || (state == DRAIN));

  // Credit bookkeeping: a finished row returns one slot, a row-end issue takes one.
  always_comb begin
    credits_next = credits;
    if (credit_ret && !row_end) begin
      credits_next = (credits == 2'd2) ? 2'd2 : credits + 2'd1;
    end else if (!credit_ret && row_end) begin
      credits_next = credits - 2'd1;
    end
  end

  // Next-state decode plus the read strobe and address for the RAM.
  always_comb begin
    next_state = state;
    mem_rd_en  = 1'b0;
    mem_addr   = '0;
    case (state)
      IDLE: begin
        if (go) next_state = WAIT_A;
      end
      WAIT_A: begin
        if (load_A_en) next_state = LOAD_A;
      end
      LOAD_A: begin
        mem_rd_en = pready;
        mem_addr  = ADDR_W'(word_cnt);
        if (a_last) next_state = LOAD_ROW;
      end
      LOAD_ROW: begin
        mem_rd_en = pready;
        mem_addr  = row_base + ADDR_W'(word_cnt);
        if (row_end) begin
          if (row_cnt == ROW_LAST) begin
            next_state = DRAIN;
          end else if (credits_next == 2'd0) begin
            next_state = HOLD;
          end
        end
      end
      HOLD: begin
        if (credits_next != 2'd0) next_state = LOAD_ROW;
      end
      DRAIN: begin
        if (credits == 2'd2) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Word/row counters, running row base address and credit count; all parked while idle.
  always_ff @(posedge clk) begin
    if (rst || (state == IDLE)) begin
      word_cnt <= '0;
      row_cnt  <= '0;
      row_base <= ROW0_BASE;
      credits  <= 2'd2;
    end else begin
      credits <= credits_next;
      if (a_last || row_end) begin
        word_cnt <= '0;
      end else if (issue_a || issue_row) begin
        word_cnt <= word_cnt + CNT_W'(1);
      end
      if (row_end) begin
        row_cnt  <= row_cnt + ROW_W'(1);
        row_base <= row_base + ROW_STEP;
      end
    end
  end

  // Delivery-side flags are the issue-side flags delayed to line up with the RAM data.
  always_ff @(posedge clk) begin
    if (rst) begin
      start_out   <= 1'b0;
      data_valid  <= 1'b0;
      data_is_A   <= 1'b0;
      load_A_done <= 1'b0;
      load_done   <= 1'b0;
      done        <= 1'b0;
    end else begin
      start_out   <= (state == IDLE) && go;
      data_valid  <= mem_rd_en;
      data_is_A   <= issue_a;
      load_A_done <= a_last;
      load_done   <= row_end;
      done        <= (state == DRAIN) && (credits == 2'd2);
    end
  end

  assign data_out = data_valid ? mem_rdata : '0;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_matrix_loader.sv
// Self-checking bench for matrix_loader: scoreboard of expected issues and deliveries.
module tb_matrix_loader;

  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 10;
  localparam int A_WORDS  = 28;
  localparam int ROW_LEN  = 28;
  localparam int NUM_ROWS = 28;

  logic              clk = 1'b0;
  logic              rst;
  logic              go;
  logic              load_A_en;
  logic              pready;
  logic              row_finish;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic              start_out;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              data_is_A;
  logic              load_A_done;
  logic              load_done;
  logic              busy;
  logic              done;

  typedef struct {
    int addr;
    bit is_a;
    bit a_done;
    bit l_done;
    bit row_start;
    bit row_end;
  } item_t;

  item_t exp_issue[$];
  item_t exp_data[$];
  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];

  int tests_run = 0;
  int tests_failed = 0;
  int rows_issued, rows_finished, a_issued;
  int done_count, start_count, load_done_count, load_a_done_count;
  bit prev_issue = 1'b0;

  matrix_loader #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .A_WORDS(A_WORDS),
    .ROW_LEN(ROW_LEN), .NUM_ROWS(NUM_ROWS)
  ) dut (
    .clk(clk), .rst(rst), .go(go), .load_A_en(load_A_en), .pready(pready),
    .row_finish(row_finish), .mem_rdata(mem_rdata), .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr), .start_out(start_out), .data_out(data_out),
    .data_valid(data_valid), .data_is_A(data_is_A), .load_A_done(load_A_done),
    .load_done(load_done), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Synchronous-read buffer RAM model.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= ram[mem_addr];
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
    end
  endtask

  task automatic reportFail(input string name, input int actual, input int required);
    tests_run++;
    tests_failed++;
    $display("[TB] FAIL %s: got %0d, required %0d", name, actual, required);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit p, input bit rf, input bit g, input bit la);
    pready     = p;
    row_finish = rf;
    go         = g;
    load_A_en  = la;
  endtask

  // Reference stream: A addresses in order, then every row word in row-major order.
  function automatic void buildExpected();
    item_t it;
    exp_issue.delete();
    exp_data.delete();
    for (int a = 0; a < A_WORDS; a++) begin
      it.addr = a; it.is_a = 1'b1; it.a_done = (a == A_WORDS - 1); it.l_done = 1'b0;
      it.row_start = 1'b0; it.row_end = 1'b0;
      exp_issue.push_back(it);
      exp_data.push_back(it);
    end
    for (int r = 0; r < NUM_ROWS; r++) begin
      for (int c = 0; c < ROW_LEN; c++) begin
        it.addr = A_WORDS + r * ROW_LEN + c; it.is_a = 1'b0; it.a_done = 1'b0;
        it.l_done = (c == ROW_LEN - 1); it.row_start = (c == 0); it.row_end = (c == ROW_LEN - 1);
        exp_issue.push_back(it);
        exp_data.push_back(it);
      end
    end
  endfunction

  function automatic void startRun();
    exp_issue.delete();
    exp_data.delete();
    rows_issued = 0; rows_finished = 0; a_issued = 0;
    done_count = 0; start_count = 0; load_done_count = 0; load_a_done_count = 0;
  endfunction

  // Monitor: checks every issued read and every delivered word against the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      prev_issue = 1'b0;
    end else begin
      if (mem_rd_en) begin
        checkOutput("issue gated by pready", pready, 1);
        if (exp_issue.size() == 0) begin
          reportFail("unexpected issue addr", mem_addr, -1);
        end else begin
          item_t it;
          it = exp_issue.pop_front();
          checkOutput("issue addr", mem_addr, it.addr);
          if (it.row_start) checkOutput("row issued with free credit", (rows_issued - rows_finished) < 2, 1);
          if (it.is_a) a_issued++;
          if (it.row_end) rows_issued++;
        end
      end
      checkOutput("data_valid one cycle after issue", data_valid, prev_issue);
      if (data_valid) begin
        if (exp_data.size() == 0) begin
          reportFail("unexpected data word", data_out, -1);
        end else begin
          item_t it;
          it = exp_data.pop_front();
          checkOutput($sformatf("data_out@%0d", it.addr), data_out, ram[it.addr]);
          checkOutput($sformatf("data_is_A@%0d", it.addr), data_is_A, it.is_a);
          checkOutput($sformatf("load_A_done@%0d", it.addr), load_A_done, it.a_done);
          checkOutput($sformatf("load_done@%0d", it.addr), load_done, it.l_done);
        end
      end else begin
        checkOutput("flags low without data", {data_is_A, load_A_done, load_done}, 0);
      end
      prev_issue = mem_rd_en;
      if (start_out) start_count++;
      if (load_done) load_done_count++;
      if (load_A_done) load_a_done_count++;
      if (done) begin
        done_count++;
        checkOutput("done after all rows returned", rows_finished, NUM_ROWS);
        checkOutput("done with stream complete", exp_data.size(), 0);
      end
    end
  end

  task automatic doReset();
    tick();
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0);
    tick();
    checkOutput("reset strobes", {mem_rd_en, start_out, data_valid, data_is_A,
                                  load_A_done, load_done, busy, done}, 0);
    checkOutput("reset mem_addr", mem_addr, 0);
    checkOutput("reset data_out", data_out, 0);
    rst = 1'b0;
    startRun();
  endtask

  // Randomised full run: pready toggles during A, random thereafter; stray go/row_finish.
  task automatic runRandom();
    int cycles, delay;
    bit p, rf, g, la;
    startRun();
    buildExpected();
    tick();
    applyStimulus(0, 0, 1, 0);
    delay  = $urandom_range(1, 5);
    cycles = 0;
    while (done_count == 0 && cycles < 20000) begin
      tick();
      if (a_issued < A_WORDS) p = (cycles % 2 == 0);
      else p = ($urandom_range(0, 3) != 0);
      la = (cycles >= delay);
      g  = (rows_issued < NUM_ROWS) && ($urandom_range(0, 15) == 0);
      rf = 1'b0;
      if (a_issued < A_WORDS) rf = ($urandom_range(0, 7) == 0);
      else if (rows_issued > rows_finished) rf = ($urandom_range(0, 9) == 0);
      applyStimulus(p, rf, g, la);
      if (rf && a_issued >= A_WORDS) rows_finished++;
      cycles++;
    end
    if (done_count == 0) reportFail("done timeout cycles", cycles, 20000);
    tick();
    applyStimulus(0, 0, 0, 0);
    checkOutput("random busy after done", busy, 0);
    checkOutput("random done pulses", done_count, 1);
    checkOutput("random start pulses", start_count, 1);
    checkOutput("random load_done pulses", load_done_count, NUM_ROWS);
    checkOutput("random load_A_done pulses", load_a_done_count, 1);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: time %0t exceeded", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int gaps, cycles, row_before;
    bit expect_start, rf;
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0);
    for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = DATA_W'($urandom);

    // Directed run: pready high, two back-to-back rows, then credit-paced rows.
    doReset();
    buildExpected();
    tick(); applyStimulus(0, 0, 1, 0);
    tick(); applyStimulus(0, 0, 1, 0);
    checkOutput("start_out after go", start_out, 1);
    checkOutput("busy after go", busy, 1);
    tick(); applyStimulus(0, 0, 0, 0);
    checkOutput("no second start_out", start_out, 0);
    tick(); applyStimulus(1, 0, 0, 1);
    tick(); applyStimulus(1, 0, 0, 1);
    checkOutput("first A issue", mem_rd_en, 1);
    checkOutput("first A addr", mem_addr, 0);
    gaps = 0;
    for (int i = 1; i < A_WORDS + 2 * ROW_LEN; i++) begin
      tick(); applyStimulus(1, 0, 0, 0);
      if (!mem_rd_en) gaps++;
    end
    checkOutput("A plus two rows gap count", gaps, 0);
    for (int i = 0; i < 3; i++) begin
      tick(); applyStimulus(1, 0, 0, 0);
    end
    checkOutput("stall without credits", mem_rd_en, 0);
    checkOutput("busy while holding", busy, 1);
    checkOutput("rows issued on initial credits", rows_issued, 2);
    checkOutput("load_done pulses before hold", load_done_count, 2);
    checkOutput("load_A_done pulses", load_a_done_count, 1);

    for (int f = 0; f < NUM_ROWS; f++) begin
      int wait_cycles;
      wait_cycles = (f == 1) ? 26 : 29;
      for (int w = 0; w < wait_cycles; w++) begin
        tick(); applyStimulus(1, 0, 0, 0);
      end
      expect_start = (rows_issued == rows_finished + 2) && (rows_issued < NUM_ROWS);
      row_before   = rows_issued;
      tick(); applyStimulus(1, 1, 0, 0);
      rows_finished++;
      tick(); applyStimulus(1, 0, 0, 0);
      if (expect_start) begin
        checkOutput($sformatf("row %0d starts after row_finish", row_before), mem_rd_en, 1);
        checkOutput($sformatf("row %0d start addr", row_before), mem_addr, A_WORDS + row_before * ROW_LEN);
      end
      if (f == 1) begin
        checkOutput("coincident finish keeps issuing", mem_rd_en, 1);
        checkOutput("coincident finish next row addr", mem_addr, A_WORDS + 3 * ROW_LEN);
      end
    end
    tick(); applyStimulus(1, 0, 0, 0);
    checkOutput("done pulse after credits return", done, 1);
    checkOutput("idle with done", busy, 0);
    tick(); applyStimulus(0, 0, 0, 0);
    checkOutput("done is one cycle", done, 0);
    checkOutput("directed done pulses", done_count, 1);
    checkOutput("directed start pulses", start_count, 1);
    checkOutput("directed load_done pulses", load_done_count, NUM_ROWS);

    // Reset in the middle of row 5.
    startRun();
    buildExpected();
    tick(); applyStimulus(1, 0, 1, 0);
    tick(); applyStimulus(1, 0, 0, 1);
    cycles = 0;
    while (rows_issued < 5 && cycles < 2000) begin
      tick();
      rf = (rows_issued == rows_finished + 2);
      applyStimulus(1, rf, 0, 1);
      if (rf) rows_finished++;
      cycles++;
    end
    checkOutput("reached row 5 before reset", rows_issued, 5);
    for (int i = 0; i < 10; i++) begin
      tick(); applyStimulus(1, 0, 0, 1);
    end
    doReset();
    for (int i = 0; i < 4; i++) begin
      tick(); applyStimulus(1, 0, 0, 0);
    end
    checkOutput("no done after reset", done_count, 0);
    checkOutput("idle after reset", busy, 0);

    // row_finish in IDLE must not add credits beyond two.
    for (int i = 0; i < 3; i++) begin
      tick(); applyStimulus(0, 1, 0, 0);
    end
    tick(); applyStimulus(0, 0, 0, 0);
    checkOutput("row_finish in idle keeps idle", busy, 0);
    checkOutput("row_finish in idle no start", start_count, 0);

    runRandom();
    runRandom();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
